// File: rtl/wb_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wb_master_pkg
// Brief    : Shared types and constants for the Wishbone command master.
// Revision : 1.0 - initial release
// ============================================================================
package wb_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] RSP_OK      = 2'b00;
    localparam logic [1:0] RSP_TIMEOUT = 2'b01;
    localparam logic [1:0] RSP_BUS_ERR = 2'b10;

    localparam int DEFAULT_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/wb_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module   : wb_timeout_ctr
// Brief    : Bus-cycle watchdog; expired is high while the count equals TIMEOUT-1.
// Revision : 1.0 - initial release
// ============================================================================
module wb_timeout_ctr #(
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    assign o_expired = (r_cnt == TO_W'(TIMEOUT - 1));

endmodule
`default_nettype wire

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Brief    : Valid/ready command stream to Wishbone classic single cycles.
//            Define WB_CMD_MASTER_ERR_EN to add the wbm_err_i termination input.
// Revision : 1.0 - initial release
// ============================================================================
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT,
    parameter int TO_W    = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                cmd_valid_i,
    output logic                cmd_ready_o,
    input  logic                cmd_we_i,
    input  logic [ADDR_W-1:0]   cmd_adr_i,
    input  logic [DATA_W-1:0]   cmd_dat_i,
    input  logic [DATA_W/8-1:0] cmd_sel_i,
    output logic                rsp_valid_o,
    input  logic                rsp_ready_i,
    output logic [DATA_W-1:0]   rsp_dat_o,
    output logic [1:0]          rsp_code_o,
    output logic                wbm_cyc_o,
    output logic                wbm_stb_o,
    output logic                wbm_we_o,
    output logic [ADDR_W-1:0]   wbm_adr_o,
    output logic [DATA_W-1:0]   wbm_dat_o,
    output logic [DATA_W/8-1:0] wbm_sel_o,
    input  logic                wbm_ack_i,
`ifdef WB_CMD_MASTER_ERR_EN
    input  logic                wbm_err_i,
`endif
    input  logic [DATA_W-1:0]   wbm_dat_i,
    output logic                busy_o
);

    state_t                r_state, w_state;
    logic                  r_cyc, w_cyc;
    logic                  r_we, w_we;
    logic [ADDR_W-1:0]     r_adr, w_adr;
    logic [DATA_W-1:0]     r_dat, w_dat;
    logic [DATA_W/8-1:0]   r_sel, w_sel;
    logic                  r_rsp_valid, w_rsp_valid;
    logic [DATA_W-1:0]     r_rsp_dat, w_rsp_dat;
    logic [1:0]            r_rsp_code, w_rsp_code;
    logic                  w_cmd_ready;
    logic                  w_err;
    logic                  w_clr;
    logic                  w_cnt_en;
    logic                  w_expired;

`ifdef WB_CMD_MASTER_ERR_EN
    assign w_err = wbm_err_i;
`else
    assign w_err = 1'b0;
`endif

    // Ready is masked while reset is held so nothing is accepted mid-reset.
    assign w_cmd_ready = (r_state == IDLE) && !wb_rst_i;
    assign w_cnt_en    = (r_state == BUS) && !wbm_ack_i && !w_err;

    wb_timeout_ctr #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .i_clr     (w_clr),
        .i_en      (w_cnt_en),
        .o_expired (w_expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state     <= IDLE;
            r_cyc       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_code  <= RSP_OK;
        end else begin
            r_state     <= w_state;
            r_cyc       <= w_cyc;
            r_we        <= w_we;
            r_adr       <= w_adr;
            r_dat       <= w_dat;
            r_sel       <= w_sel;
            r_rsp_valid <= w_rsp_valid;
            r_rsp_dat   <= w_rsp_dat;
            r_rsp_code  <= w_rsp_code;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cyc       = r_cyc;
        w_we        = r_we;
        w_adr       = r_adr;
        w_dat       = r_dat;
        w_sel       = r_sel;
        w_rsp_valid = r_rsp_valid;
        w_rsp_dat   = r_rsp_dat;
        w_rsp_code  = r_rsp_code;
        w_clr       = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i && w_cmd_ready) begin
                    w_we    = cmd_we_i;
                    w_adr   = cmd_adr_i;
                    w_dat   = cmd_dat_i;
                    w_sel   = cmd_sel_i;
                    w_cyc   = 1'b1;
                    w_clr   = 1'b1;
                    w_state = BUS;
                end
            end
            BUS: begin
                // Priority: ack, then err, then timeout.
                if (wbm_ack_i) begin
                    w_cyc       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_code  = RSP_OK;
                    w_rsp_dat   = r_we ? '0 : wbm_dat_i;
                    w_state     = RESP;
                end else if (w_err) begin
                    w_cyc       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_code  = RSP_BUS_ERR;
                    w_rsp_dat   = '0;
                    w_state     = RESP;
                end else if (w_expired) begin
                    w_cyc       = 1'b0;
                    w_rsp_valid = 1'b1;
                    w_rsp_code  = RSP_TIMEOUT;
                    w_rsp_dat   = '0;
                    w_state     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    w_rsp_valid = 1'b0;
                    w_state     = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
                w_cyc   = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = w_cmd_ready;
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_dat_o   = r_rsp_dat;
    assign rsp_code_o  = r_rsp_code;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_cyc;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = r_sel;
    assign busy_o      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Brief    : Directed self-checking bench for wb_cmd_master (TIMEOUT = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_cmd_master;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_code;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        ack;
    logic [31:0] rdat;
    logic        busy;
`ifdef WB_CMD_MASTER_ERR_EN
    logic        err;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    wb_cmd_master #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (4),
        .TO_W    (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid_i (cmd_valid),
        .cmd_ready_o (cmd_ready),
        .cmd_we_i    (cmd_we),
        .cmd_adr_i   (cmd_adr),
        .cmd_dat_i   (cmd_dat),
        .cmd_sel_i   (cmd_sel),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_dat_o   (rsp_dat),
        .rsp_code_o  (rsp_code),
        .wbm_cyc_o   (cyc),
        .wbm_stb_o   (stb),
        .wbm_we_o    (we),
        .wbm_adr_o   (adr),
        .wbm_dat_o   (wdat),
        .wbm_sel_o   (sel),
        .wbm_ack_i   (ack),
`ifdef WB_CMD_MASTER_ERR_EN
        .wbm_err_i   (err),
`endif
        .wbm_dat_i   (rdat),
        .busy_o      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        cmd_we    = w;
        cmd_adr   = a;
        cmd_dat   = d;
        cmd_sel   = s;
        cmd_valid = 1'b1;
        tick;
        cmd_valid = 1'b0;
    endtask

    task automatic release_rsp;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if ({cyc, stb, we} !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b required 000", {cyc, stb, we}); end
        n_checks++; if (adr !== 32'h0) begin n_fail++; $display("FAIL reset_adr: got %h required 0", adr); end
        n_checks++; if ({wdat, sel} !== 36'h0) begin n_fail++; $display("FAIL reset_dat_sel: got %h required 0", {wdat, sel}); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
        n_checks++; if ({rsp_dat, rsp_code} !== 34'h0) begin n_fail++; $display("FAIL reset_rsp: got %h required 0", {rsp_dat, rsp_code}); end
        n_checks++; if ({busy, cmd_ready} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_ready: got %b required 00", {busy, cmd_ready}); end
        rst = 1'b0;
        tick;
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", cmd_ready); end
        // Stray ack while idle must not move anything.
        ack = 1'b1;
        tick;
        ack = 1'b0;
        n_checks++; if ({rsp_valid, busy, cyc} !== 3'b000) begin n_fail++; $display("FAIL idle_ack_ignored: got %b required 000", {rsp_valid, busy, cyc}); end
    endtask

    task automatic test_write;
        int ncyc;
        ncyc = 0;
        issue(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF);
        n_checks++; if ({cyc, stb, we} !== 3'b111) begin n_fail++; $display("FAIL wr_ctrl: got %b required 111", {cyc, stb, we}); end
        n_checks++; if (adr !== 32'h3000_0004) begin n_fail++; $display("FAIL wr_adr: got %h required 30000004", adr); end
        n_checks++; if (wdat !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL wr_dat: got %h required deadbeef", wdat); end
        n_checks++; if (sel !== 4'hF) begin n_fail++; $display("FAIL wr_sel: got %h required f", sel); end
        n_checks++; if ({busy, cmd_ready} !== 2'b10) begin n_fail++; $display("FAIL wr_busy_ready: got %b required 10", {busy, cmd_ready}); end
        if (cyc) ncyc++;
        rdat = 32'hFFFF_FFFF;
        tick;
        if (cyc) ncyc++;
        ack = 1'b1;
        tick;
        ack = 1'b0;
        if (cyc) ncyc++;
        n_checks++; if (ncyc !== 2) begin n_fail++; $display("FAIL wr_cyc_len: got %0d required 2", ncyc); end
        n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rsp_valid: got %b required 1", rsp_valid); end
        n_checks++; if (rsp_code !== 2'b00) begin n_fail++; $display("FAIL wr_rsp_code: got %b required 00", rsp_code); end
        n_checks++; if (rsp_dat !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_dat: got %h required 0", rsp_dat); end
        n_checks++; if ({we, adr} !== {1'b1, 32'h3000_0004}) begin n_fail++; $display("FAIL wr_hold_after: got %h required 130000004", {we, adr}); end
        release_rsp;
        n_checks++; if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL wr_release: got %b required 001", {rsp_valid, busy, cmd_ready}); end
    endtask

    task automatic test_read;
        issue(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        n_checks++; if ({cyc, we, adr} !== {1'b1, 1'b0, 32'h3000_0010}) begin n_fail++; $display("FAIL rd_start: got %h required 030000010 with cyc", {cyc, we, adr}); end
        ack  = 1'b1;
        rdat = 32'h1234_5678;
        tick;
        ack  = 1'b0;
        rdat = 32'h0;
        n_checks++; if (cyc !== 1'b0) begin n_fail++; $display("FAIL rd_cyc_drop: got %b required 0", cyc); end
        n_checks++; if ({rsp_valid, rsp_code} !== 3'b100) begin n_fail++; $display("FAIL rd_rsp: got %b required 100", {rsp_valid, rsp_code}); end
        n_checks++; if (rsp_dat !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rsp_dat: got %h required 12345678", rsp_dat); end
        // Response back-pressure: everything must hold while a new command waits.
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_adr   = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_checks++;
            if ({rsp_valid, rsp_code, rsp_dat, cmd_ready, cyc} !== {1'b1, 2'b00, 32'h1234_5678, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL rd_stall_%0d: got v=%b c=%b d=%h rdy=%b cyc=%b required v=1 c=00 d=12345678 rdy=0 cyc=0",
                         i, rsp_valid, rsp_code, rsp_dat, cmd_ready, cyc);
            end
        end
        cmd_valid = 1'b0;
        release_rsp;
        n_checks++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL rd_release: got %b required 01", {rsp_valid, cmd_ready}); end
    endtask

    task automatic test_timeout;
        int ncyc;
        ncyc = 0;
        issue(1'b0, 32'h3000_0020, 32'h0, 4'h1);
        while (cyc === 1'b1 && ncyc < 20) begin
            ncyc++;
            tick;
        end
        n_checks++; if (ncyc !== 4) begin n_fail++; $display("FAIL to_cyc_len: got %0d required 4", ncyc); end
        n_checks++; if ({rsp_valid, rsp_code} !== 3'b101) begin n_fail++; $display("FAIL to_rsp: got %b required 101", {rsp_valid, rsp_code}); end
        n_checks++; if (rsp_dat !== 32'h0) begin n_fail++; $display("FAIL to_rsp_dat: got %h required 0", rsp_dat); end
        ack  = 1'b1;
        rdat = 32'hAAAA_5555;
        tick;
        ack  = 1'b0;
        n_checks++; if ({rsp_valid, rsp_code, rsp_dat, cyc} !== {1'b1, 2'b01, 32'h0, 1'b0}) begin n_fail++; $display("FAIL to_late_ack: got v=%b c=%b d=%h cyc=%b required v=1 c=01 d=0 cyc=0", rsp_valid, rsp_code, rsp_dat, cyc); end
        release_rsp;
    endtask

    task automatic test_ack_at_timeout;
        issue(1'b0, 32'h3000_0030, 32'h0, 4'hF);
        repeat (3) tick;
        n_checks++; if (cyc !== 1'b1) begin n_fail++; $display("FAIL at_cyc_4th: got %b required 1", cyc); end
        ack  = 1'b1;
        rdat = 32'hCAFE_F00D;
        tick;
        ack  = 1'b0;
        rdat = 32'h0;
        n_checks++; if ({rsp_valid, rsp_code} !== 3'b100) begin n_fail++; $display("FAIL at_rsp_code: got %b required 100", {rsp_valid, rsp_code}); end
        n_checks++; if (rsp_dat !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL at_rsp_dat: got %h required cafef00d", rsp_dat); end
        release_rsp;
    endtask

    task automatic test_back_to_back;
        issue(1'b1, 32'h3000_0040, 32'h0000_0001, 4'h3);
        ack = 1'b1;
        tick;
        ack = 1'b0;
        // Command offered in the same cycle the response is consumed.
        cmd_we    = 1'b0;
        cmd_adr   = 32'h3000_0044;
        cmd_valid = 1'b1;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        n_checks++; if ({rsp_valid, cyc, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL b2b_no_overlap: got %b required 001", {rsp_valid, cyc, cmd_ready}); end
        tick;
        cmd_valid = 1'b0;
        n_checks++; if ({cyc, we, adr} !== {1'b1, 1'b0, 32'h3000_0044}) begin n_fail++; $display("FAIL b2b_accept: got %h required 030000044 with cyc", {cyc, we, adr}); end
        ack  = 1'b1;
        rdat = 32'h0000_0055;
        tick;
        ack  = 1'b0;
        n_checks++; if ({rsp_valid, rsp_dat} !== {1'b1, 32'h0000_0055}) begin n_fail++; $display("FAIL b2b_rsp: got %h required 100000055", {rsp_valid, rsp_dat}); end
        release_rsp;
    endtask

    task automatic test_reset_mid_bus;
        issue(1'b1, 32'h3000_0050, 32'h1111_2222, 4'hF);
        tick;
        n_checks++; if (cyc !== 1'b1) begin n_fail++; $display("FAIL rm_cyc_before: got %b required 1", cyc); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if ({cyc, stb} !== 2'b00) begin n_fail++; $display("FAIL rm_async_drop: got %b required 00", {cyc, stb}); end
        n_checks++; if ({busy, cmd_ready, adr} !== 34'h0) begin n_fail++; $display("FAIL rm_in_reset: got %h required 0", {busy, cmd_ready, adr}); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        tick;
        n_checks++; if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin n_fail++; $display("FAIL rm_after: got %b required 010", {rsp_valid, cmd_ready, busy}); end
    endtask

`ifdef WB_CMD_MASTER_ERR_EN
    task automatic test_err;
        issue(1'b0, 32'h3000_0060, 32'h0, 4'hF);
        err  = 1'b1;
        rdat = 32'h7777_7777;
        tick;
        err  = 1'b0;
        n_checks++; if ({rsp_valid, rsp_code, rsp_dat, cyc} !== {1'b1, 2'b10, 32'h0, 1'b0}) begin n_fail++; $display("FAIL err_rsp: got v=%b c=%b d=%h cyc=%b required v=1 c=10 d=0 cyc=0", rsp_valid, rsp_code, rsp_dat, cyc); end
        release_rsp;
        issue(1'b0, 32'h3000_0064, 32'h0, 4'hF);
        err  = 1'b1;
        ack  = 1'b1;
        rdat = 32'h8888_9999;
        tick;
        err  = 1'b0;
        ack  = 1'b0;
        n_checks++; if ({rsp_valid, rsp_code, rsp_dat} !== {1'b1, 2'b00, 32'h8888_9999}) begin n_fail++; $display("FAIL err_ack_prio: got v=%b c=%b d=%h required v=1 c=00 d=88889999", rsp_valid, rsp_code, rsp_dat); end
        release_rsp;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        ack       = 1'b0;
        rdat      = 32'h0;
`ifdef WB_CMD_MASTER_ERR_EN
        err       = 1'b0;
`endif
        test_reset;
        test_write;
        test_read;
        test_timeout;
        test_ack_at_timeout;
        test_back_to_back;
        test_reset_mid_bus;
`ifdef WB_CMD_MASTER_ERR_EN
        test_err;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone classic (B4, non-pipelined) initiator. It turns a simple valid/ready command stream into single Wishbone read/write cycles and returns each result on a valid/ready response stream.
- It is the master-side counterpart of the user-area Wishbone slave port. It drives on-chip peripheral slaves (sonar front-end config, filter coefficient RAM) from internal controllers without management-SoC involvement.
- One transaction outstanding at a time. A timeout guards against non-responding slaves.

Parameters:
- ADDR_W, 32, address width of command and Wishbone address.
- DATA_W, 32, data width; SEL width is DATA_W/8.
- TIMEOUT, 255, max cycles with cyc/stb asserted before abort; legal range 1..2^TO_W-1.
- TO_W, 8, timeout counter width.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted when valid&ready.
- cmd_we_i  in  1  1=write, 0=read.
- cmd_adr_i  in  ADDR_W  target address.
- cmd_dat_i  in  DATA_W  write data.
- cmd_sel_i  in  DATA_W/8  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_dat_o  out  DATA_W  read data (0 for writes and aborts).
- rsp_code_o  out  2  00 OK, 01 TIMEOUT, 10 BUS_ERR.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls.
- wbm_adr_o  out  ADDR_W; wbm_dat_o  out  DATA_W; wbm_sel_o  out  DATA_W/8.
- wbm_ack_i  in  1; wbm_dat_i  in  DATA_W.
- busy_o  out  1  high in any state but IDLE.

Behaviour:
- Reset (async, immediate): state=IDLE. cyc/stb/we=0. adr/dat/sel=0. rsp_valid_o=0. rsp_dat_o=0. rsp_code_o=00. timeout counter=0. busy_o=0. cmd_ready_o=0 during reset, 1 after release.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - cmd_ready_o=1.
  - On valid&ready at edge N: register we/adr/dat/sel onto wbm_* outputs, set cyc=stb=1, clear counter, go BUS.
  - cyc/stb are visible in the cycle after edge N.
- BUS:
  - cmd_ready_o=0. All wbm_* outputs are held stable.
  - Counter increments each cycle without ack.
  - ack sampled high at an edge: cyc=stb=0 at that same edge; rsp_dat_o=wbm_dat_i if read, else 0; rsp_code_o=00; rsp_valid_o=1; go RESP.
  - Counter reaching TIMEOUT-1 without ack: cyc=stb=0, rsp_dat_o=0, rsp_code_o=01, rsp_valid_o=1, go RESP.
  - Total bus occupancy is therefore at most TIMEOUT cycles.
  - Simultaneous ack and timeout: ack wins (code 00).
- RESP:
  - rsp_* held stable until rsp_ready_i.
  - On valid&ready: rsp_valid_o=0, go IDLE.
  - Next command can be accepted no earlier than the following cycle; no same-cycle response-accept/command-accept overlap.
- Throughput: at best one transaction per 3 cycles (accept, ack, response).
- wbm_ack_i in IDLE or RESP is ignored; no state or output change.
- wbm_we_o/adr/dat/sel retain their last values after the cycle ends. Slaves must qualify on cyc&stb.
- Reset asserted mid-BUS drops cyc/stb asynchronously. The pending transaction is lost and no response is produced.
- cmd_* inputs are not sampled outside IDLE.

Optional Feature:
- Macro WB_CMD_MASTER_ERR_EN.
- Defined: adds input port wbm_err_i (1). In BUS, err terminates the cycle exactly like ack, with rsp_dat_o=0 and rsp_code_o=10. Priority is ack > err > timeout.
- Undefined: port absent; code 10 is never produced.

Decomposition:
- Package wb_master_pkg holds:
  - state enum {IDLE, BUS, RESP};
  - response code constants RSP_OK=2'b00, RSP_TIMEOUT=2'b01, RSP_BUS_ERR=2'b10;
  - default TIMEOUT.
- One sub-module, wb_timeout_ctr (TO_W-bit counter with clear/enable inputs and an expired output at TIMEOUT-1), instantiated once.

Test Plan:
- Write: cmd we=1, adr=0x3000_0004, dat=0xDEAD_BEEF, sel=0xF; slave acks on 2nd cycle of stb -> wbm_* carry those values; cyc/stb high exactly 2 cycles; rsp_code=00, rsp_dat=0.
- Read: adr=0x3000_0010; slave returns 0x1234_5678 with ack on 1st cycle -> rsp_dat=0x1234_5678, code 00. With rsp_ready_i held low 5 cycles -> response stable, cmd_ready_o=0 throughout.
- Timeout with TIMEOUT=4, no ack -> cyc/stb high exactly 4 cycles, then rsp_code=01, rsp_dat=0. A late ack arriving in RESP is ignored.
- Ack coincident with the final timeout cycle -> rsp_code=00 and data captured.
- Reset asserted on 2nd BUS cycle -> cyc/stb low without a clock edge; after release rsp_valid_o=0 and cmd_ready_o=1.
- With WB_CMD_MASTER_ERR_EN: err on 1st cycle -> rsp_code=10, rsp_dat=0. ack+err together -> code 00.
